// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack port plus the decode-side valid/ready handshake.
// The fetch unit connects to the master modport; memory and decode connect to the slave modport.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        jump;
  logic        br_taken;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, pc_plus4,
    input  imem_ack, imem_rdata, instr_ready, jump, br_taken, flush, flush_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, pc_plus4,
    output imem_ack, imem_rdata, instr_ready, jump, br_taken, flush, flush_pc
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch unit: PC register, req/ack instruction fetch, valid/ready hand-off to decode.
// Optional MIPS_DELAY_SLOT_EN: taken jumps/branches redirect after one delay-slot instruction.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH,
    VALID,
    DISCARD
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] pc_plus4_q;
`ifdef MIPS_DELAY_SLOT_EN
  logic        pend_v_q;
  logic [31:0] pend_q;
`endif

  logic        taken;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic [31:0] flush_tgt;
  logic        abandon;

  assign flush_tgt = {bus.flush_pc[31:2], 2'b00};

  // A request is outstanding only when req is actually on the bus and this cycle brings no ack.
  assign abandon = ((state_q == FETCH && req_q) || state_q == DISCARD) && !bus.imem_ack;

  always_comb begin
    taken = bus.jump | bus.br_taken;
    if (bus.jump) begin
      target = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else begin
      target = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end
`ifdef MIPS_DELAY_SLOT_EN
    next_pc = pend_v_q ? pend_q : pc_plus4_q;
`else
    next_pc = taken ? target : pc_plus4_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc_plus4_q <= '0;
`ifdef MIPS_DELAY_SLOT_EN
      pend_v_q   <= 1'b0;
      pend_q     <= '0;
`endif
    end else if (bus.flush) begin
      pc_q    <= flush_tgt;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
`ifdef MIPS_DELAY_SLOT_EN
      pend_v_q <= 1'b0;
`endif
      // addr_q keeps the abandoned address on the bus until the memory acks it
      if (abandon) begin
        state_q <= DISCARD;
      end else begin
        state_q <= FETCH;
        addr_q  <= flush_tgt;
      end
    end else begin
      case (state_q)
        FETCH: begin
          req_q <= 1'b1;
          if (req_q && bus.imem_ack) begin
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= addr_q;
            pc_plus4_q <= addr_q + 32'd4;
            state_q    <= VALID;
          end
        end
        VALID: begin
          if (bus.instr_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            pc_q    <= next_pc;
            addr_q  <= next_pc;
            state_q <= FETCH;
`ifdef MIPS_DELAY_SLOT_EN
            if (pend_v_q) begin
              pend_v_q <= 1'b0;
            end else if (taken) begin
              pend_v_q <= 1'b1;
              pend_q   <= target;
            end
`endif
          end
        end
        DISCARD: begin
          if (bus.imem_ack) begin
            addr_q  <= pc_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus a randomized run against a PC-sequence model.
// Build with +define+MIPS_DELAY_SLOT_EN to check the delay-slot variant.
module tb_mips_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] w);
    return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [31:0] w);
    int off;
    off = int'($signed(w[15:0]));
    return pc4 + 32'(off * 4);
  endfunction

  task automatic idle_inputs();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.br_taken    = 1'b0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL wait_req: imem_req=%b required 1 within 50 cycles", bus.imem_req);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_valid: instr_valid=%b required 1 within 50 cycles", bus.instr_valid);
    end
  endtask

  // Memory side: answer the current request after `delay` idle cycles, returning the address served.
  task automatic serve(input logic [31:0] word, input int delay, output logic [31:0] addr);
    wait_req();
    repeat (delay) @(negedge clk);
    addr = bus.imem_addr;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  task automatic accept(input logic j, input logic b);
    wait_valid();
    bus.instr_ready = 1'b1;
    bus.jump        = j;
    bus.br_taken    = b;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.br_taken    = 1'b0;
  endtask

  // Redirect with flush in the same cycle as an ack so the next fetch is exactly pc.
  task automatic sync_to(input logic [31:0] pc);
    wait_req();
    bus.flush      = 1'b1;
    bus.flush_pc   = pc;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    checks++; if (bus.pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc_plus4: got %h want 0", bus.pc_plus4); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      w = 32'h2000_0000 | ($urandom & 32'h03FF_FFFF);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_addr[%0d]: req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 32'(4 * i));
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = w;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w || bus.opcode !== w[31:26]) begin
        failures++;
        $display("FAIL seq_valid[%0d]: valid=%b instr=%h op=%h want 1 %h %h", i, bus.instr_valid, bus.instr, bus.opcode, w, w[31:26]);
      end
      checks++;
      if (bus.instr_pc !== 32'(4 * i) || bus.pc_plus4 !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL seq_pc[%0d]: instr_pc=%h pc_plus4=%h want %h %h", i, bus.instr_pc, bus.pc_plus4, 32'(4 * i), 32'(4 * i + 4));
      end
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_pulse[%0d]: instr_valid=%b want 0 after accept", i, bus.instr_valid);
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] a;
    sync_to(32'h0040_0000);
    serve(32'h0800_0010, 1, a);
    checks++; if (a !== 32'h0040_0000) begin failures++; $display("FAIL jump_src: addr=%h want 00400000", a); end
    accept(1'b1, 1'b0);
`ifdef MIPS_DELAY_SLOT_EN
    serve(32'h0000_0000, 0, a);
    checks++; if (a !== 32'h0040_0004) begin failures++; $display("FAIL jump_slot: addr=%h want 00400004", a); end
    accept(1'b0, 1'b0);
`endif
    wait_req();
    checks++; if (bus.imem_addr !== 32'h0000_0040) begin failures++; $display("FAIL jump_target: addr=%h want 00000040", bus.imem_addr); end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    sync_to(32'h0000_0100);
    serve(32'h1000_FFFF, 0, a);
    accept(1'b0, 1'b1);
`ifdef MIPS_DELAY_SLOT_EN
    serve(32'h0000_0000, 0, a);
    checks++; if (a !== 32'h0000_0104) begin failures++; $display("FAIL branch_slot: addr=%h want 00000104", a); end
    accept(1'b0, 1'b0);
`endif
    wait_req();
    checks++; if (bus.imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL branch_target: addr=%h want 00000100", bus.imem_addr); end
  endtask

  task automatic test_stall();
    logic [31:0] a, w;
    w = 32'h8C00_0000 | ($urandom & 32'h03FF_FFFF);
    sync_to(32'h0000_0300);
    serve(w, 0, a);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w || bus.opcode !== w[31:26] || bus.imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h op=%h req=%b want 1 %h %h 0", i, bus.instr_valid, bus.instr, bus.opcode, bus.imem_req, w, w[31:26]);
      end
      @(negedge clk);
    end
    accept(1'b0, 1'b0);
    wait_req();
    checks++; if (bus.imem_addr !== 32'h0000_0304) begin failures++; $display("FAIL stall_resume: addr=%h want 00000304", bus.imem_addr); end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    sync_to(32'h0000_0500);
    wait_req();
    bus.flush = 1'b1; bus.flush_pc = 32'h0000_0200;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0500) begin
      failures++;
      $display("FAIL flush_hold: req=%b addr=%h want 1 00000500", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL flush_hold2: req=%b want 1", bus.imem_req); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0200) begin
      failures++;
      $display("FAIL flush_drop: valid=%b req=%b addr=%h want 0 1 00000200", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    serve(32'h2400_0001, 0, a);
    checks++; if (bus.instr_pc !== 32'h0000_0200) begin failures++; $display("FAIL flush_fetch: instr_pc=%h want 00000200", bus.instr_pc); end
    // flush coinciding with a jump accept, misaligned target
    bus.instr_ready = 1'b1; bus.jump = 1'b1; bus.flush = 1'b1; bus.flush_pc = 32'h0000_030B;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0308) begin
      failures++;
      $display("FAIL flush_accept: valid=%b req=%b addr=%h want 0 1 00000308", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; bus.flush = 1'b1; bus.flush_pc = 32'h0000_0444;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0444) begin
      failures++;
      $display("FAIL flush_ack: valid=%b req=%b addr=%h want 0 1 00000444", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_delay_slot();
    logic [31:0] a;
    sync_to(32'h0000_0100);
    serve(32'h1000_001F, 0, a);
    accept(1'b0, 1'b1);
    serve(32'h0000_0000, 0, a);
`ifdef MIPS_DELAY_SLOT_EN
    checks++; if (a !== 32'h0000_0104) begin failures++; $display("FAIL ds_slot: addr=%h want 00000104", a); end
    accept(1'b1, 1'b1);
    wait_req();
    checks++; if (bus.imem_addr !== 32'h0000_0180) begin failures++; $display("FAIL ds_target: addr=%h want 00000180", bus.imem_addr); end
`else
    checks++; if (a !== 32'h0000_0180) begin failures++; $display("FAIL br_immediate: addr=%h want 00000180", a); end
    accept(1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, pend, a, w, pc4, tgt;
    logic        pend_v, j, b;
    exp_pc = $urandom & 32'hFFFF_FFFC;
    pend_v = 1'b0;
    pend   = '0;
    sync_to(exp_pc);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      serve(w, int'($urandom_range(0, 3)), a);
      checks++; if (a !== exp_pc) begin failures++; $display("FAIL rand_addr[%0d]: addr=%h want %h", i, a, exp_pc); end
      pc4 = exp_pc + 32'd4;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w || bus.instr_pc !== exp_pc || bus.pc_plus4 !== pc4) begin
        failures++;
        $display("FAIL rand_out[%0d]: valid=%b instr=%h pc=%h pc4=%h want 1 %h %h %h", i, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus4, w, exp_pc, pc4);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      tgt = j ? jump_target(pc4, w) : branch_target(pc4, w);
      accept(j, b);
`ifdef MIPS_DELAY_SLOT_EN
      if (pend_v) begin
        exp_pc = pend; pend_v = 1'b0;
      end else begin
        exp_pc = pc4;
        if (j || b) begin pend = tgt; pend_v = 1'b1; end
      end
`else
      exp_pc = (j || b) ? tgt : pc4;
`endif
    end
  endtask

  task automatic test_reset_midfetch();
    sync_to(32'h0000_0800);
    wait_req();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: req=%b valid=%b want 0 0", bus.imem_req, bus.instr_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_req();
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_mid_addr: addr=%h want 0", bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall();
    test_flush();
    test_delay_slot();
    test_random();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
